// File: rtl/pulse_transmitter_output_shaper_if.sv
// rtl/pulse_transmitter_output_shaper_if.sv - symbol, config and pin bundle for the output shaper
interface pulse_transmitter_output_shaper_if #(
  parameter int CARRIER_W = 16,
  parameter int SYMCNT_W  = 8
);
  logic                 en;
  logic                 sym_strobe;
  logic                 sym_level;
  logic                 carrier_en;
  logic [CARRIER_W-1:0] carrier_high;
  logic [CARRIER_W-1:0] carrier_low;
  logic                 invert;
  logic                 idle_level;
  logic [SYMCNT_W-1:0]  sym_target;
  logic                 irq_clear;
  logic                 pulse_out;
  logic                 carrier_out;
  logic                 envelope;
  logic [SYMCNT_W-1:0]  sym_count;
  logic                 done_irq;

  modport master (
    output en, sym_strobe, sym_level, carrier_en, carrier_high, carrier_low,
           invert, idle_level, sym_target, irq_clear,
    input  pulse_out, carrier_out, envelope, sym_count, done_irq
  );

  modport slave (
    input  en, sym_strobe, sym_level, carrier_en, carrier_high, carrier_low,
           invert, idle_level, sym_target, irq_clear,
    output pulse_out, carrier_out, envelope, sym_count, done_irq
  );
endinterface

// File: rtl/pulse_transmitter_output_shaper.sv
// rtl/pulse_transmitter_output_shaper.sv - envelope/carrier shaping, symbol counting and done interrupt
module pulse_transmitter_output_shaper #(
  parameter int CARRIER_W = 16,
  parameter int SYMCNT_W  = 8
) (
  input  logic clk,
  input  logic rst,
  pulse_transmitter_output_shaper_if.slave bus
);

  logic                 envelope_q;
  logic                 carrier_q;
  logic                 pulse_q;
  logic [CARRIER_W-1:0] phase_cnt;
  logic [SYMCNT_W-1:0]  sym_count_q;
  logic                 done_q;

  logic [SYMCNT_W-1:0]  sym_next;
  logic                 accept;
  logic                 mark_start;
  logic                 done_set;

  // A strobe is only accepted while enabled; a rising mark re-aligns the carrier.
  assign accept     = bus.en & bus.sym_strobe;
  assign mark_start = accept & bus.sym_level & ~envelope_q;
  assign sym_next   = sym_count_q + 1'b1;
  assign done_set   = accept & (bus.sym_target != '0) & (sym_next == bus.sym_target);

  // Envelope follows the level sampled with each accepted strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      envelope_q <= 1'b0;
    end else if (!bus.en) begin
      envelope_q <= 1'b0;
    end else if (bus.sym_strobe) begin
      envelope_q <= bus.sym_level;
    end
  end

  // Two-phase carrier down-counter; each reload samples the phase length live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q <= 1'b0;
      phase_cnt <= '0;
    end else if (!bus.en) begin
      carrier_q <= 1'b0;
      phase_cnt <= '0;
    end else if (mark_start) begin
      carrier_q <= 1'b1;
      phase_cnt <= bus.carrier_high;
    end else if (phase_cnt == '0) begin
      carrier_q <= ~carrier_q;
      phase_cnt <= carrier_q ? bus.carrier_low : bus.carrier_high;
    end else begin
      phase_cnt <= phase_cnt - 1'b1;
    end
  end

  // Pin register built from the previous envelope/carrier state, idle level when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else if (!bus.en) begin
      pulse_q <= bus.idle_level;
    end else begin
      pulse_q <= (envelope_q & (bus.carrier_en ? carrier_q : 1'b1)) ^ bus.invert;
    end
  end

  // Symbol counter restarts whenever the transmitter is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_count_q <= '0;
    end else if (!bus.en) begin
      sym_count_q <= '0;
    end else if (bus.sym_strobe) begin
      sym_count_q <= sym_next;
    end
  end

  // Sticky done flag survives disable; a coincident set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_set | (done_q & ~bus.irq_clear);
    end
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.carrier_out = carrier_q;
  assign bus.envelope    = envelope_q;
  assign bus.sym_count   = sym_count_q;
  assign bus.done_irq    = done_q;

endmodule

// File: tb/tb_pulse_transmitter_output_shaper.sv
// tb/tb_pulse_transmitter_output_shaper.sv - self-checking bench for the output shaper
module tb_pulse_transmitter_output_shaper;
  localparam int CW = 16;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pulse_transmitter_output_shaper_if #(.CARRIER_W(CW), .SYMCNT_W(SW)) bus ();

  pulse_transmitter_output_shaper #(.CARRIER_W(CW), .SYMCNT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: carrier tracked as elapsed cycles against the current phase length.
  logic          m_pulse, m_car, m_env, m_done;
  logic [SW-1:0] m_cnt;
  int            m_len, m_el;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pulse <= 0; m_car <= 0; m_env <= 0; m_cnt <= 0; m_done <= 0;
      m_len <= 1; m_el <= 1;
    end else if (!bus.en) begin
      m_pulse <= bus.idle_level; m_car <= 0; m_env <= 0; m_cnt <= 0;
      m_len <= 1; m_el <= 1;
      m_done <= m_done && !bus.irq_clear;
    end else begin
      m_pulse <= (m_env && (bus.carrier_en ? m_car : 1'b1)) ^ bus.invert;
      if (bus.sym_strobe) begin
        m_env <= bus.sym_level;
        m_cnt <= SW'((int'(m_cnt) + 1) % 256);
      end
      m_done <= (bus.sym_strobe && bus.sym_target != 0 &&
                 ((int'(m_cnt) + 1) % 256) == int'(bus.sym_target)) || (m_done && !bus.irq_clear);
      if (bus.sym_strobe && bus.sym_level && !m_env) begin
        m_car <= 1; m_len <= int'(bus.carrier_high) + 1; m_el <= 1;
      end else if (m_el >= m_len) begin
        m_car <= !m_car;
        m_len <= (m_car ? int'(bus.carrier_low) : int'(bus.carrier_high)) + 1;
        m_el  <= 1;
      end else begin
        m_el <= m_el + 1;
      end
    end
  end

  wire [SW+3:0] dut_v = {bus.pulse_out, bus.carrier_out, bus.envelope, bus.sym_count, bus.done_irq};
  wire [SW+3:0] mdl_v = {m_pulse, m_car, m_env, m_cnt, m_done};

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_cmp++;
    if (dut_v !== '0) begin
      n_bad++; $display("FAIL reset_state got=%h want=0", dut_v);
    end
    rst = 1'b0;
    bus.en = 1'b1; bus.carrier_en = 1'b1; bus.carrier_high = 2; bus.carrier_low = 4;
    bus.sym_strobe = 1'b1; bus.sym_level = 1'b1;
    tick;
    bus.sym_strobe = 1'b0;
    repeat (3) tick;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dut_v !== '0) begin
      n_bad++; $display("FAIL async_reset got=%h want=0", dut_v);
    end
    @(negedge clk);
    rst = 1'b0; bus.en = 1'b0; bus.idle_level = 1'b1;
    tick;
    n_cmp++;
    if (bus.pulse_out !== 1'b1) begin
      n_bad++; $display("FAIL idle_level got=%b want=1", bus.pulse_out);
    end
  endtask

  task automatic test_carrier;
    logic exp_car, prev_car;
    bus.idle_level = 1'b0; bus.en = 1'b1; bus.invert = 1'b0; bus.carrier_en = 1'b1;
    bus.carrier_high = 2; bus.carrier_low = 4;
    repeat (5) tick;
    bus.sym_strobe = 1'b1; bus.sym_level = 1'b1;
    tick;
    bus.sym_strobe = 1'b0;
    prev_car = 1'b1;
    for (int j = 0; j < 17; j++) begin
      exp_car = (j % 8) < 3;
      n_cmp++;
      if (bus.carrier_out !== exp_car) begin
        n_bad++; $display("FAIL carrier_phase j=%0d got=%b want=%b", j, bus.carrier_out, exp_car);
      end
      if (j > 0) begin
        n_cmp++;
        if (bus.pulse_out !== prev_car) begin
          n_bad++; $display("FAIL carrier_pulse j=%0d got=%b want=%b", j, bus.pulse_out, prev_car);
        end
      end
      n_cmp++;
      if (dut_v !== mdl_v) begin
        n_bad++; $display("FAIL carrier_model j=%0d got=%h want=%h", j, dut_v, mdl_v);
      end
      prev_car = exp_car;
      tick;
    end
  endtask

  task automatic test_invert_plain;
    logic lv [3];
    lv[0] = 1'b1; lv[1] = 1'b0; lv[2] = 1'b1;
    bus.en = 1'b0; tick;
    bus.en = 1'b1; bus.carrier_en = 1'b0; bus.invert = 1'b1;
    for (int t = 0; t <= 30; t++) begin
      bus.sym_strobe = (t % 10 == 0) && (t < 30);
      bus.sym_level  = lv[(t < 30) ? t / 10 : 2];
      tick;
      bus.sym_strobe = 1'b0;
      if (t >= 1) begin
        n_cmp++;
        if (bus.pulse_out !== !lv[(t - 1) / 10]) begin
          n_bad++; $display("FAIL invert_plain t=%0d got=%b want=%b", t, bus.pulse_out, !lv[(t - 1) / 10]);
        end
      end
    end
  endtask

  task automatic test_done;
    bus.en = 1'b0; bus.irq_clear = 1'b1; tick;
    bus.irq_clear = 1'b0; bus.en = 1'b1; bus.sym_target = 3; bus.carrier_en = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      bus.sym_strobe = 1'b1; bus.sym_level = s[0];
      tick;
      bus.sym_strobe = 1'b0;
      n_cmp++;
      if ({bus.sym_count, bus.done_irq} !== {SW'(s), s == 3}) begin
        n_bad++; $display("FAIL done_count s=%0d got=%0d/%b want=%0d/%b", s, bus.sym_count, bus.done_irq, s, s == 3);
      end
      tick;
    end
    bus.sym_target = 4; bus.sym_strobe = 1'b1; bus.irq_clear = 1'b1;
    tick;
    bus.sym_strobe = 1'b0;
    n_cmp++;
    if ({bus.sym_count, bus.done_irq} !== {SW'(4), 1'b1}) begin
      n_bad++; $display("FAIL done_set_wins got=%0d/%b want=4/1", bus.sym_count, bus.done_irq);
    end
    tick;
    bus.irq_clear = 1'b0;
    n_cmp++;
    if (bus.done_irq !== 1'b0) begin
      n_bad++; $display("FAIL done_clear got=%b want=0", bus.done_irq);
    end
  endtask

  task automatic test_en_drop;
    bus.en = 1'b0; tick;
    bus.en = 1'b1; bus.idle_level = 1'b0; bus.invert = 1'b0; bus.carrier_en = 1'b1;
    bus.carrier_high = 5; bus.carrier_low = 3; bus.sym_target = 0;
    bus.sym_strobe = 1'b1; bus.sym_level = 1'b1;
    tick;
    bus.sym_strobe = 1'b0;
    repeat (2) tick;
    bus.en = 1'b0;
    tick;
    n_cmp++;
    if (dut_v[SW+3:SW+1] !== 3'b000 || bus.sym_count !== '0) begin
      n_bad++; $display("FAIL en_drop got=%h want=pulse/car/env/count zero", dut_v);
    end
    bus.en = 1'b1; bus.sym_strobe = 1'b1; bus.sym_level = 1'b1;
    tick;
    bus.sym_strobe = 1'b0;
    n_cmp++;
    if (bus.sym_count !== SW'(1)) begin
      n_bad++; $display("FAIL reenable_count got=%0d want=1", bus.sym_count);
    end
    for (int j = 0; j < 7; j++) begin
      n_cmp++;
      if (bus.carrier_out !== (j < 6)) begin
        n_bad++; $display("FAIL reenable_phase j=%0d got=%b want=%b", j, bus.carrier_out, j < 6);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back_wrap;
    bus.en = 1'b0; bus.irq_clear = 1'b1; tick;
    bus.irq_clear = 1'b0; bus.en = 1'b1; bus.sym_target = 0;
    bus.carrier_high = 1; bus.carrier_low = 0;
    for (int i = 0; i < 260; i++) begin
      bus.sym_strobe = 1'b1; bus.sym_level = 1'($urandom);
      tick;
      n_cmp++;
      if (bus.sym_count !== SW'((i + 1) % 256) || bus.done_irq !== 1'b0) begin
        n_bad++; $display("FAIL wrap i=%0d got=%0d/%b want=%0d/0", i, bus.sym_count, bus.done_irq, (i + 1) % 256);
      end
      n_cmp++;
      if (dut_v !== mdl_v) begin
        n_bad++; $display("FAIL wrap_model i=%0d got=%h want=%h", i, dut_v, mdl_v);
      end
    end
    bus.sym_strobe = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      bus.en           = ($urandom_range(0, 15) != 0);
      bus.sym_strobe   = ($urandom_range(0, 2) == 0);
      bus.sym_level    = 1'($urandom);
      bus.carrier_en   = 1'($urandom);
      bus.carrier_high = CW'($urandom_range(0, 3));
      bus.carrier_low  = CW'($urandom_range(0, 3));
      bus.invert       = ($urandom_range(0, 7) == 0);
      bus.idle_level   = 1'($urandom);
      bus.sym_target   = SW'($urandom_range(0, 6));
      bus.irq_clear    = ($urandom_range(0, 7) == 0);
      tick;
      n_cmp++;
      if (dut_v !== mdl_v) begin
        n_bad++; $display("FAIL random i=%0d got=%h want=%h", i, dut_v, mdl_v);
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.sym_strobe = 1'b0; bus.sym_level = 1'b0; bus.carrier_en = 1'b0;
    bus.carrier_high = '0; bus.carrier_low = '0; bus.invert = 1'b0; bus.idle_level = 1'b0;
    bus.sym_target = '0; bus.irq_clear = 1'b0;
    repeat (2) tick;
    test_reset;
    test_carrier;
    test_invert_plain;
    test_done;
    test_en_drop;
    test_back_to_back_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
